wb_imc_bridge: RTL and testbench

WB_IMC_BRIDGE -- requirements
Module: wb_imc_bridge

---
 rtl/wb_imc_bridge.sv | 205 ++++++++++++++++++++
 tb/tb_wb_imc_bridge.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_imc_bridge.sv
// Wishbone slave bridge to the IMC accelerator buffers and MAC controller.
// A single transaction is in flight at a time; all side effects fire on the ACK cycle.
module wb_imc_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        ib_wr_en,
  output logic [31:0] ib_wr_data,
  input  logic        ib_full,
  output logic        wt_wr_en,
  output logic [31:0] wt_wr_data,
  input  logic        wt_full,
  output logic        ob_rd_en,
  input  logic [31:0] ob_rd_data,
  input  logic        ob_empty,
  output logic        mac_start,
  output logic [2:0]  mac_opcode,
  input  logic [1:0]  ctrl_ext_state,
  input  logic [2:0]  ctrl_int_state,
  input  logic [7:0]  buf_flags
);

  localparam int unsigned DW = 32;
  localparam int unsigned EW = 5;
  localparam int unsigned CW = 8;

  localparam logic [7:0] OFF_IB   = 8'h00;
  localparam logic [7:0] OFF_WT   = 8'h04;
  localparam logic [7:0] OFF_OB   = 8'h08;
  localparam logic [7:0] OFF_STAT = 8'h0C;
  localparam logic [7:0] OFF_CTRL = 8'h10;
  localparam logic [7:0] OFF_ERR  = 8'h14;

  typedef enum logic [1:0] {IDLE, WAIT_W, WAIT_R, ACK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    off_q;
  logic          we_q;
  logic [3:0]    sel_q;
  logic [DW-1:0] dat_q;
  logic [EW-1:0] err_q;

  logic          req_hit;
  logic [7:0]    off;
  logic          we;
  logic [3:0]    sel;
  logic [4:0]    dat_lo;
  logic          is_ib, is_wt, is_ob, is_ctrl, is_errw, full_sel, blocked;
  logic          enter_ack, timed_out;
  logic          push_ib, push_wt, pop_ob, ctrl_ld, start;
  logic [EW-1:0] err_set, err_clr;
  logic [DW-1:0] rd_data, status;

  assign req_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);

  // Decode the live bus while idle, the captured request while stalled.
  always_comb begin
    off    = off_q;
    we     = we_q;
    sel    = sel_q;
    dat_lo = dat_q[4:0];
    if (state_q == IDLE) begin
      off    = wbs_adr_i[7:0];
      we     = wbs_we_i;
      sel    = wbs_sel_i;
      dat_lo = wbs_dat_i[4:0];
    end
  end

  assign is_ib    = we & (off == OFF_IB);
  assign is_wt    = we & (off == OFF_WT);
  assign is_ob    = ~we & (off == OFF_OB);
  assign is_ctrl  = we & (off == OFF_CTRL);
  assign is_errw  = we & (off == OFF_ERR);
  assign full_sel = (sel == 4'hF);
  assign blocked  = (state_q == WAIT_W) ? (is_ib ? ib_full : wt_full) : ob_empty;
  assign status   = {14'b0, ctrl_int_state, ctrl_ext_state, mac_opcode, buf_flags, 2'b00};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enter_ack = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_hit) begin
          if ((is_ib && ib_full) || (is_wt && wt_full)) begin
            state_d = WAIT_W;
            cnt_d   = '0;
          end else if (is_ob && ob_empty) begin
            state_d = WAIT_R;
            cnt_d   = '0;
          end else begin
            state_d   = ACK;
            enter_ack = 1'b1;
          end
        end
      end
      WAIT_W, WAIT_R: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (!blocked) begin
          state_d   = ACK;
          enter_ack = 1'b1;
        end else if (cnt_q == TIMEOUT) begin
          state_d   = ACK;
          enter_ack = 1'b1;
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Side effects and read data for the cycle about to enter ACK.
  always_comb begin
    push_ib = enter_ack & ~timed_out & is_ib & full_sel;
    push_wt = enter_ack & ~timed_out & is_wt & full_sel;
    pop_ob  = enter_ack & ~timed_out & is_ob;
    ctrl_ld = enter_ack & is_ctrl & sel[0];
    start   = ctrl_ld & dat_lo[0] & (ctrl_ext_state == 2'd0);
    err_set = '0;
    if (enter_ack) begin
      if (timed_out) err_set[2:0] = {is_ob, is_wt, is_ib};
      if ((is_ib | is_wt) & ~full_sel) err_set[3] = 1'b1;
      if (ctrl_ld & dat_lo[0] & (ctrl_ext_state != 2'd0)) err_set[4] = 1'b1;
    end
    err_clr = (enter_ack & is_errw) ? dat_lo : '0;
    rd_data = '0;
    if (!we) begin
      case (off)
        OFF_OB:   rd_data = timed_out ? '0 : ob_rd_data;
        OFF_STAT: rd_data = status;
        OFF_ERR:  rd_data = DW'(err_q);
        default:  rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      off_q <= '0;
      we_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
    end else if (state_q == IDLE && req_hit) begin
      off_q <= wbs_adr_i[7:0];
      we_q  <= wbs_we_i;
      sel_q <= wbs_sel_i;
      dat_q <= wbs_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      ib_wr_en   <= 1'b0;
      wt_wr_en   <= 1'b0;
      ob_rd_en   <= 1'b0;
      mac_start  <= 1'b0;
      mac_opcode <= '0;
      err_q      <= '0;
    end else begin
      wbs_ack_o <= enter_ack;
      wbs_dat_o <= enter_ack ? rd_data : '0;
      ib_wr_en  <= push_ib;
      wt_wr_en  <= push_wt;
      ob_rd_en  <= pop_ob;
      mac_start <= start;
      if (ctrl_ld) mac_opcode <= dat_lo[3:1];
      // set wins over a same-cycle clear
      err_q <= (err_q & ~err_clr) | err_set;
    end
  end

  assign ib_wr_data = dat_q;
  assign wt_wr_data = dat_q;

endmodule

// File: tb/tb_wb_imc_bridge.sv
// Randomized self-checking bench for wb_imc_bridge against a transaction-level model
// of latency, push/pop, read data, ERR and opcode.
module tb_wb_imc_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TMO  = 255;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        ib_wr_en, ib_full;
  logic [31:0] ib_wr_data;
  logic        wt_wr_en, wt_full;
  logic [31:0] wt_wr_data;
  logic        ob_rd_en, ob_empty;
  logic [31:0] ob_rd_data;
  logic        mac_start;
  logic [2:0]  mac_opcode;
  logic [1:0]  ctrl_ext_state;
  logic [2:0]  ctrl_int_state;
  logic [7:0]  buf_flags;

  int         n_chk = 0;
  int         n_bad = 0;
  logic [4:0] m_err;
  logic [2:0] m_op;

  always #5 clk = ~clk;

  wb_imc_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ib_wr_en(ib_wr_en), .ib_wr_data(ib_wr_data), .ib_full(ib_full),
    .wt_wr_en(wt_wr_en), .wt_wr_data(wt_wr_data), .wt_full(wt_full),
    .ob_rd_en(ob_rd_en), .ob_rd_data(ob_rd_data), .ob_empty(ob_empty),
    .mac_start(mac_start), .mac_opcode(mac_opcode),
    .ctrl_ext_state(ctrl_ext_state), .ctrl_int_state(ctrl_int_state),
    .buf_flags(buf_flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus transaction; k = cycles the target flag stays blocking after acceptance.
  task automatic run_txn(input logic [7:0] off, input logic we, input logic [3:0] sel,
                         input logic [31:0] dat, input int k_in);
    logic        is_ib, is_wt, is_ob, is_ctrl, is_errw, tmo, exp_start, exp_ib, exp_wt, exp_pop;
    int          k, j, exp_dly, got_dly, n_ack, n_ib, n_wt, n_pop, n_st, n_stray, n_nz;
    logic [31:0] exp_rd, got_rd, got_wd;
    logic [4:0]  set_b;
    is_ib   = we && off == 8'h00;
    is_wt   = we && off == 8'h04;
    is_ob   = !we && off == 8'h08;
    is_ctrl = we && off == 8'h10;
    is_errw = we && off == 8'h14;
    k       = (is_ib || is_wt || is_ob) ? k_in : 0;
    tmo     = (k > TMO + 1);
    exp_dly = tmo ? TMO + 1 : k;
    exp_ib  = is_ib && !tmo && sel == 4'hF;
    exp_wt  = is_wt && !tmo && sel == 4'hF;
    exp_pop = is_ob && !tmo;
    exp_start = is_ctrl && sel[0] && dat[0] && ctrl_ext_state == 2'd0;
    exp_rd  = '0;
    if (!we) begin
      case (off)
        8'h08:   exp_rd = tmo ? 32'h0 : ob_rd_data;
        8'h0C:   exp_rd = {14'b0, ctrl_int_state, ctrl_ext_state, m_op, buf_flags, 2'b00};
        8'h14:   exp_rd = {27'b0, m_err};
        default: exp_rd = '0;
      endcase
    end

    ib_full  = 1'($urandom);
    wt_full  = 1'($urandom);
    ob_empty = 1'($urandom);
    if (is_ib) ib_full = (k > 0);
    if (is_wt) wt_full = (k > 0);
    if (is_ob) ob_empty = (k > 0);
    wbs_adr_i = {BASE[31:8], off};
    wbs_we_i  = we;
    wbs_sel_i = sel;
    wbs_dat_i = dat;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;

    got_dly = -1; n_ack = 0; n_ib = 0; n_wt = 0; n_pop = 0; n_st = 0; n_stray = 0; n_nz = 0;
    got_rd = '0; got_wd = '0;
    j = 0;
    while (j < 400) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        n_ack++;
        if (got_dly < 0) begin got_dly = j; got_rd = wbs_dat_o; end
      end else if (wbs_dat_o != 0) n_nz++;
      if (ib_wr_en) begin n_ib++; got_wd = ib_wr_data; if (!wbs_ack_o) n_stray++; end
      if (wt_wr_en) begin n_wt++; got_wd = wt_wr_data; if (!wbs_ack_o) n_stray++; end
      if (ob_rd_en) begin n_pop++; if (!wbs_ack_o) n_stray++; end
      if (mac_start) begin n_st++; if (!wbs_ack_o) n_stray++; end
      if (got_dly >= 0) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        ib_full = 1'b0; wt_full = 1'b0; ob_empty = 1'b0;
        if (j >= got_dly + 2) break;
      end else if (k > 0 && j == k - 1) begin
        if (is_ib) ib_full = 1'b0;
        if (is_wt) wt_full = 1'b0;
        if (is_ob) ob_empty = 1'b0;
      end
      j++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    ib_full = 1'b0; wt_full = 1'b0; ob_empty = 1'b0;

    check("ack_delay", 32'(got_dly), 32'(exp_dly));
    check("ack_count", 32'(n_ack), 32'd1);
    check("rd_data", got_rd, exp_rd);
    check("dat_outside_ack", 32'(n_nz), 32'd0);
    check("ib_push", 32'(n_ib), 32'(exp_ib));
    check("wt_push", 32'(n_wt), 32'(exp_wt));
    check("ob_pop", 32'(n_pop), 32'(exp_pop));
    check("mac_start", 32'(n_st), 32'(exp_start));
    check("pulse_outside_ack", 32'(n_stray), 32'd0);
    if (exp_ib || exp_wt) check("push_data", got_wd, dat);

    set_b = '0;
    if (tmo) set_b[2:0] = {is_ob, is_wt, is_ib};
    if ((is_ib || is_wt) && sel != 4'hF) set_b[3] = 1'b1;
    if (is_ctrl && sel[0] && dat[0] && ctrl_ext_state != 2'd0) set_b[4] = 1'b1;
    if (is_errw) m_err = (m_err & ~dat[4:0]) | set_b;
    else m_err = m_err | set_b;
    if (is_ctrl && sel[0]) m_op = dat[3:1];
    check("opcode", 32'(mac_opcode), 32'(m_op));
  endtask

  task automatic run_miss(input logic [31:0] adr, input logic stb);
    int n_resp;
    n_resp = 0;
    wbs_adr_i = adr; wbs_we_i = 1'($urandom); wbs_sel_i = 4'hF; wbs_dat_i = $urandom;
    wbs_cyc_i = 1'b1; wbs_stb_i = stb;
    repeat (6) begin
      @(posedge clk); #1;
      if (wbs_ack_o || ib_wr_en || wt_wr_en || ob_rd_en || mac_start) n_resp++;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("ignored_req", 32'(n_resp), 32'd0);
  endtask

  task automatic read_err();
    run_txn(8'h14, 1'b0, 4'hF, 32'h0, 0);
  endtask

  initial begin
    logic [7:0] offs [9];
    int         n_resp, r, kk;
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h02, 8'hFC};
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    ib_full = 1'b0; wt_full = 1'b0; ob_empty = 1'b0; ob_rd_data = 32'h0BAD_F00D;
    ctrl_ext_state = 2'd0; ctrl_int_state = 3'd5; buf_flags = 8'h96;
    m_err = '0; m_op = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_pulses", 32'({ib_wr_en, wt_wr_en, ob_rd_en, mac_start}), 32'd0);
    check("rst_opcode", 32'(mac_opcode), 32'd0);
    wb_rst_i = 1'b0;

    run_txn(8'h00, 1'b1, 4'hF, 32'hA5A5_1234, 0);
    run_txn(8'h04, 1'b1, 4'hF, 32'h1111_2222, 10);
    read_err();
    ob_rd_data = 32'hDEAD_BEEF;
    run_txn(8'h08, 1'b0, 4'hF, 32'h0, 300);
    check("v3_err_model", 32'(m_err), 32'h4);
    read_err();
    run_txn(8'h14, 1'b1, 4'hF, 32'h1F, 0);
    ctrl_ext_state = 2'd0;
    run_txn(8'h10, 1'b1, 4'h1, 32'h0000_0007, 0);
    ctrl_ext_state = 2'd2;
    run_txn(8'h10, 1'b1, 4'h1, 32'h0000_0007, 0);
    read_err();
    ctrl_ext_state = 2'd0;
    run_txn(8'h14, 1'b1, 4'hF, 32'h1F, 0);
    run_txn(8'h00, 1'b1, 4'h3, 32'h1234_5678, 0);
    read_err();
    run_txn(8'h14, 1'b1, 4'hF, 32'h08, 0);
    read_err();
    run_txn(8'h0C, 1'b0, 4'hF, 32'h0, 0);
    run_txn(8'h04, 1'b1, 4'hF, 32'hCAFE_0001, 256);
    run_txn(8'h00, 1'b1, 4'hF, 32'hCAFE_0002, 257);
    read_err();

    // master abandons a stalled read
    n_resp = 0;
    ob_empty = 1'b1; wbs_adr_i = {BASE[31:8], 8'h08}; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    repeat (5) begin @(posedge clk); #1; if (wbs_ack_o || ob_rd_en) n_resp++; end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (wbs_ack_o || ob_rd_en) n_resp++; end
    ob_empty = 1'b0;
    check("cyc_drop", 32'(n_resp), 32'd0);
    read_err();

    // reset while stalled on a full input buffer
    n_resp = 0;
    ib_full = 1'b1; wbs_adr_i = {BASE[31:8], 8'h00}; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
    wbs_dat_i = 32'h5555_AAAA; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (wbs_ack_o || ib_wr_en) n_resp++; end
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    if (wbs_ack_o || ib_wr_en) n_resp++;
    check("rst_mid_opcode", 32'(mac_opcode), 32'd0);
    wb_rst_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; ib_full = 1'b0;
    m_err = '0; m_op = '0;
    repeat (3) begin @(posedge clk); #1; if (wbs_ack_o || ib_wr_en) n_resp++; end
    check("rst_mid_abort", 32'(n_resp), 32'd0);
    run_txn(8'h20, 1'b0, 4'hF, 32'h0, 0);
    read_err();

    for (int i = 0; i < 160; i++) begin
      ob_rd_data     = $urandom;
      ctrl_ext_state = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      ctrl_int_state = 3'($urandom);
      buf_flags      = 8'($urandom);
      r  = $urandom_range(0, 19);
      kk = (r < 12) ? 0 : (r < 19) ? $urandom_range(1, 12) : $urandom_range(250, 262);
      run_txn(offs[$urandom_range(0, 8)], 1'($urandom),
              ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, $urandom, kk);
      if (i % 10 == 0) begin
        run_miss(BASE ^ (32'h1 << $urandom_range(8, 31)), 1'b1);
        run_miss(BASE | 32'($urandom_range(0, 255)), 1'b0);
      end
      if (i % 16 == 0) read_err();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
